// File: rtl/serial_word_ring.sv
// serial_word_ring: serial-load circular word store.
// Bits arrive LSB-first into a staging word (mem[1]); every WORD_WIDTH active
// bit-times the whole ring advances one word and the completed word lands in
// mem[0], which drives dout. Supports hold, optional clear-on-reset and
// lossless recirculation of the staging word when write is low.
module serial_word_ring #(
    parameter int WORD_WIDTH     = 8,
    parameter int WORD_COUNT     = 22,
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter int IDX_W          = $clog2(WORD_COUNT),
    parameter int BIT_W          = $clog2(WORD_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write,
    input  logic                  din,
    input  logic                  hold,
    output logic [WORD_WIDTH-1:0] dout,
    output logic [IDX_W-1:0]      word_idx,
    output logic [BIT_W-1:0]      bit_idx,
    output logic                  frame
);

    logic [WORD_WIDTH-1:0] r_mem [WORD_COUNT];
    logic [IDX_W-1:0]      r_word_idx;
    logic [BIT_W-1:0]      r_bit_idx;
    logic                  r_frame;

    logic                  w_nb;
    logic                  w_last;
    logic [WORD_WIDTH-1:0] w_staged;

    // Next serial bit, staging word after one shift, and end-of-word detect.
    // NOTE: combinational logic uses blocking '=' and assigns every signal on every path, so no latch is inferred.
    always_comb begin
        w_nb     = write ? din : r_mem[1][0];
        w_staged = {w_nb, r_mem[1][WORD_WIDTH-1:1]};
        w_last   = (r_bit_idx == BIT_W'(WORD_WIDTH - 1));
    end

    // Bit/word counters and the one-cycle frame strobe after each rotation.
    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_idx  <= '0;
            r_word_idx <= '0;
            r_frame    <= 1'b0;
        end else if (hold) begin
            r_frame    <= 1'b0;
        end else begin
            r_frame <= w_last;
            if (w_last) begin
                r_bit_idx  <= '0;
                r_word_idx <= (r_word_idx == IDX_W'(WORD_COUNT - 1)) ? '0
                                                                      : r_word_idx + IDX_W'(1);
            end else begin
                r_bit_idx  <= r_bit_idx + BIT_W'(1);
            end
        end
    end

    // Word storage: shift into the staging word, or rotate the whole ring at end of word.
    // NOTE: the storage array is cleared only when CLEAR_ON_RESET is set; otherwise reset leaves contents intact by design.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (CLEAR_ON_RESET) begin
                for (int k = 0; k < WORD_COUNT; k++) begin
                    r_mem[k] <= '0;
                end
            end
        end else if (!hold) begin
            if (w_last) begin
                r_mem[0] <= w_staged;
                for (int k = 1; k < WORD_COUNT - 1; k++) begin
                    r_mem[k] <= r_mem[k+1];
                end
                r_mem[WORD_COUNT-1] <= r_mem[0];
            end else begin
                r_mem[1] <= w_staged;
            end
        end
    end

    assign dout     = r_mem[0];
    assign word_idx = r_word_idx;
    assign bit_idx  = r_bit_idx;
    assign frame    = r_frame;

endmodule

// File: tb/tb_serial_word_ring.sv
// tb_serial_word_ring: directed bench for serial_word_ring.
// Instances: a (8x4, clear on reset), b (8x4, no clear, same inputs as a),
// c (4x2, clear on reset, own inputs).
module tb_serial_word_ring;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for a and b
    logic reset, write, din, hold;
    logic [7:0] a_dout, b_dout;
    logic [1:0] a_word_idx, b_word_idx;
    logic [2:0] a_bit_idx, b_bit_idx;
    logic       a_frame, b_frame;

    // Stimulus and outputs for c
    logic       c_reset, c_write, c_din, c_hold;
    logic [3:0] c_dout;
    logic       c_word_idx;
    logic [1:0] c_bit_idx;
    logic       c_frame;

    serial_word_ring #(.WORD_WIDTH(8), .WORD_COUNT(4), .CLEAR_ON_RESET(1'b1)) u_a (
        .clk(clk), .reset(reset), .write(write), .din(din), .hold(hold),
        .dout(a_dout), .word_idx(a_word_idx), .bit_idx(a_bit_idx), .frame(a_frame)
    );

    serial_word_ring #(.WORD_WIDTH(8), .WORD_COUNT(4), .CLEAR_ON_RESET(1'b0)) u_b (
        .clk(clk), .reset(reset), .write(write), .din(din), .hold(hold),
        .dout(b_dout), .word_idx(b_word_idx), .bit_idx(b_bit_idx), .frame(b_frame)
    );

    serial_word_ring #(.WORD_WIDTH(4), .WORD_COUNT(2), .CLEAR_ON_RESET(1'b1)) u_c (
        .clk(clk), .reset(c_reset), .write(c_write), .din(c_din), .hold(c_hold),
        .dout(c_dout), .word_idx(c_word_idx), .bit_idx(c_bit_idx), .frame(c_frame)
    );

    typedef struct {
        logic [1:0] idx;
        logic [7:0] word;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec;
    int   n_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; sample #1 after the edge; score any frame produced by instance a.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (a_frame === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_frame", a_frame, 0);
            end else begin
                e = sb_q.pop_front();
                check("sb_dout", a_dout, e.word);
                check("sb_word_idx", a_word_idx, e.idx);
            end
        end
    endtask

    // Shift bits lo..hi of w into a/b with write=1.
    task automatic shift_bits(input logic [7:0] w, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            write = 1'b1;
            din   = w[i];
            tick();
        end
        write = 1'b0;
    endtask

    // Full word load into a/b; expectation for a goes on the scoreboard first.
    task automatic load_word(input logic [7:0] w, input logic [1:0] idx);
        exp_t e;
        e.idx  = idx;
        e.word = w;
        sb_q.push_back(e);
        shift_bits(w, 0, 7);
    endtask

    // Full nibble load into c.
    task automatic load_c(input logic [3:0] w);
        for (int i = 0; i < 4; i++) begin
            c_write = 1'b1;
            c_din   = w[i];
            tick();
        end
        c_write = 1'b0;
    endtask

    // Watchdog: the sequence is a fixed number of cycles, so this only fires on a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    logic [7:0] seq [4];

    initial begin
        exp_t e;
        logic [7:0] exp_dout;

        n_vec   = 0;
        n_err   = 0;
        reset   = 1'b1;
        write   = 1'b0;
        din     = 1'b0;
        hold    = 1'b0;
        c_reset = 1'b1;
        c_write = 1'b0;
        c_din   = 1'b0;
        c_hold  = 1'b0;
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;

        // Reset state
        tick();
        check("rst_dout", a_dout, 8'h00);
        check("rst_word_idx", a_word_idx, 0);
        check("rst_bit_idx", a_bit_idx, 0);
        check("rst_frame", a_frame, 0);
        reset = 1'b0;

        // Single load of 0xA5
        load_word(8'hA5, 2'd1);
        check("load_frame", a_frame, 1);
        check("load_bit_idx", a_bit_idx, 0);
        tick();
        check("frame_one_cycle", a_frame, 0);
        check("load_dout_stable", a_dout, 8'hA5);
        check("load_bit_idx_adv", a_bit_idx, 1);

        // Re-clear, then fill with four words and recirculate
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reclear_dout", a_dout, 8'h00);
        load_word(8'h11, 2'd1);
        load_word(8'h22, 2'd2);
        load_word(8'h33, 2'd3);
        load_word(8'h44, 2'd0);
        for (int k = 0; k < 4; k++) begin
            e.idx  = 2'(k + 1);
            e.word = seq[k];
            sb_q.push_back(e);
        end
        write = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (i % 8 == 3) begin
                exp_dout = (i < 8) ? 8'h44 : seq[(i / 8) - 1];
                check("recirc_dout_stable", a_dout, exp_dout);
                check("recirc_bit_idx", a_bit_idx, 4);
                check("recirc_frame_low", a_frame, 0);
            end
        end
        check("recirc_end_dout", a_dout, 8'h44);
        check("recirc_end_word_idx", a_word_idx, 0);

        // Hold mid-load of 0xC3 at bit_idx 3
        e.idx  = 2'd1;
        e.word = 8'hC3;
        sb_q.push_back(e);
        shift_bits(8'hC3, 0, 2);
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            write = i[0];
            din   = ~i[1];
            tick();
            check("hold_bit_idx", a_bit_idx, 3);
            check("hold_dout", a_dout, 8'h44);
            check("hold_word_idx", a_word_idx, 0);
            check("hold_frame", a_frame, 0);
        end
        hold = 1'b0;
        shift_bits(8'hC3, 3, 7);
        check("b_after_hold_dout", b_dout, 8'hC3);

        // Reset mid-word at bit_idx 5, with hold asserted alongside
        shift_bits(8'h5A, 0, 4);
        check("pre_rst_bit_idx", a_bit_idx, 5);
        reset = 1'b1;
        hold  = 1'b1;
        tick();
        reset = 1'b0;
        hold  = 1'b0;
        check("midrst_a_bit_idx", a_bit_idx, 0);
        check("midrst_a_word_idx", a_word_idx, 0);
        check("midrst_a_dout", a_dout, 8'h00);
        check("midrst_a_frame", a_frame, 0);
        check("midrst_b_bit_idx", b_bit_idx, 0);
        check("midrst_b_word_idx", b_word_idx, 0);
        check("midrst_b_dout", b_dout, 8'hC3);

        // Partial bits survive in the staging word: 0x22 with 5 bits of 0x5A shifted in -> 0xD1
        e.idx  = 2'd1;
        e.word = 8'h00;
        sb_q.push_back(e);
        write = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
        end
        check("staging_b_dout", b_dout, 8'hD1);
        check("staging_b_word_idx", b_word_idx, 1);
        check("staging_b_frame", b_frame, 1);

        // 4-bit x 2-word instance: swap behaviour and word_idx toggling
        hold = 1'b1;
        tick();
        check("c_rst_dout", c_dout, 4'h0);
        check("c_rst_word_idx", c_word_idx, 0);
        check("c_rst_bit_idx", c_bit_idx, 0);
        check("c_rst_frame", c_frame, 0);
        c_reset = 1'b0;
        load_c(4'h9);
        check("c_load9_dout", c_dout, 4'h9);
        check("c_load9_word_idx", c_word_idx, 1);
        check("c_load9_frame", c_frame, 1);
        load_c(4'h6);
        check("c_load6_dout", c_dout, 4'h6);
        check("c_load6_word_idx", c_word_idx, 0);
        c_write = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) begin
                tick();
                if (i == 1) begin
                    check("c_recirc_frame_low", c_frame, 0);
                end
            end
            check("c_recirc_dout", c_dout, (r % 2 == 0) ? 4'h9 : 4'h6);
            check("c_recirc_word_idx", c_word_idx, (r % 2 == 0) ? 1 : 0);
            check("c_recirc_frame", c_frame, 1);
        end

        check("sb_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
